// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/control unit:
// register index width, PC width, scoreboard counter width and FSM state encodings.
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX  = 5;
    localparam int ADDR_LEN = 32;
    localparam int SB_CNT_W = 3;

    typedef enum logic [1:0] {
        HZ_DRAIN  = 2'd0,
        HZ_RUN    = 2'd1,
        HZ_FREEZE = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: one down-counter per architectural register holding the
// number of cycles a consumer must still wait for an in-flight load result.
// x0 is never tracked. An issue write to a register overrides its decrement.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_IDX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_en,
    input  logic                wr_en,
    input  logic [REG_W-1:0]    wr_idx,
    input  logic [SB_CNT_W-1:0] wr_val,
    input  logic [REG_W-1:0]    rd_a_idx,
    input  logic [REG_W-1:0]    rd_b_idx,
    output logic                busy_a,
    output logic                busy_b
);

    localparam int NREG = 2 ** REG_W;

    logic [SB_CNT_W-1:0] cnt_q [NREG];
    logic [SB_CNT_W-1:0] cnt_d [NREG];

    // Next counter values: decrement nonzero entries, newest issue write wins.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (dec_en && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
            if (wr_en && (wr_idx == REG_W'(r))) begin
                cnt_d[r] = wr_val;
            end
        end
        cnt_d[0] = '0;
    end

    // Counter array registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Read ports: a register is busy while its counter is nonzero (x0 never).
    always_comb begin
        busy_a = (rd_a_idx != '0) && (cnt_q[rd_a_idx] != '0);
        busy_b = (rd_b_idx != '0) && (cnt_q[rd_b_idx] != '0);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hold/flush/redirect control for the 5-stage RV32 pipe.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// HZ_DRAIN  | after reset: bubbles into IF/ID and ID/EX, PC held
// HZ_RUN    | normal flow; ex_jmp > load-use stall > id_jmp
// HZ_FREEZE | memory wait: every stage held, scoreboard frozen
//
// RUN/FREEZE follow mem_busy combinationally: a cycle with mem_busy=1 behaves
// as FREEZE, and the first cycle with mem_busy=0 already behaves as RUN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W     = REG_IDX,
    parameter int ADDR_W    = ADDR_LEN,
    parameter int LOAD_LAT  = 1,
    parameter int DRAIN_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs1_idx,
    input  logic              id_rs1_use,
    input  logic [REG_W-1:0]  id_rs2_idx,
    input  logic              id_rs2_use,
    input  logic [REG_W-1:0]  id_rd_idx,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              id_jmp,
    input  logic [ADDR_W-1:0] id_jmp_addr,
    input  logic              ex_jmp,
    input  logic [ADDR_W-1:0] ex_jmp_addr,
    input  logic              mem_busy,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
    output logic [31:0]       perf_freeze_cnt,
`endif
    output logic              if_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_hold,
    output logic              idex_flush,
    output logic              exmem_hold,
    output logic              memwb_hold,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_addr
);

    localparam logic [3:0]          DRAIN_LAST = 4'(DRAIN_CYC - 1);
    localparam logic [SB_CNT_W-1:0] LOAD_VAL   = SB_CNT_W'(LOAD_LAT);

    hz_state_e  state_q, state_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;

    logic in_drain, run, freeze;
    logic busy_a, busy_b;
    logic stall, issue, sb_wr;

    // Operating mode for this cycle.
    always_comb begin
        in_drain = (state_q == HZ_DRAIN);
        run      = !in_drain && !mem_busy;
        freeze   = !in_drain && mem_busy;
        stall    = run && id_valid &&
                   ((id_rs1_use && busy_a) || (id_rs2_use && busy_b));
        issue    = run && id_valid && !stall && !ex_jmp;
        sb_wr    = issue && id_rd_we;
    end

    hazard_scoreboard #(
        .REG_W (REG_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .dec_en   (run),
        .wr_en    (sb_wr),
        .wr_idx   (id_rd_idx),
        .wr_val   (id_is_load ? LOAD_VAL : '0),
        .rd_a_idx (id_rs1_idx),
        .rd_b_idx (id_rs2_idx),
        .busy_a   (busy_a),
        .busy_b   (busy_b)
    );

    // Next state and drain timer.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            HZ_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = HZ_RUN;
                end else begin
                    drain_cnt_d = drain_cnt_q + 4'd1;
                end
            end
            HZ_RUN, HZ_FREEZE: begin
                state_d = mem_busy ? HZ_FREEZE : HZ_RUN;
            end
            default: begin
                state_d     = HZ_DRAIN;
                drain_cnt_d = '0;
            end
        endcase
    end

    // FSM state and drain counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HZ_DRAIN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Stage controls: drain bubbles, freeze holds, or RUN priority chain.
    always_comb begin
        if_hold       = 1'b0;
        ifid_hold     = 1'b0;
        ifid_flush    = 1'b0;
        idex_hold     = 1'b0;
        idex_flush    = 1'b0;
        exmem_hold    = 1'b0;
        memwb_hold    = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        if (in_drain) begin
            if_hold    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (freeze) begin
            if_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
            memwb_hold = 1'b1;
        end else if (ex_jmp) begin
            redirect      = 1'b1;
            redirect_addr = ex_jmp_addr;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
        end else if (stall) begin
            if_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
        end else if (id_jmp) begin
            redirect      = 1'b1;
            redirect_addr = id_jmp_addr;
            ifid_flush    = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q,  perf_stall_d;
    logic [31:0] perf_flush_q,  perf_flush_d;
    logic [31:0] perf_freeze_q, perf_freeze_d;

    // Saturating event counters.
    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_flush_d  = perf_flush_q;
        perf_freeze_d = perf_freeze_q;
        if (stall && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (redirect && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
        if (freeze && (perf_freeze_q != '1)) begin
            perf_freeze_d = perf_freeze_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q  <= '0;
            perf_flush_q  <= '0;
            perf_freeze_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_flush_q  <= perf_flush_d;
            perf_freeze_q <= perf_freeze_d;
        end
    end

    assign perf_stall_cnt  = perf_stall_q;
    assign perf_flush_cnt  = perf_flush_q;
    assign perf_freeze_cnt = perf_freeze_q;
`endif

endmodule
